// File: rtl/cla_pkg.sv
// Shared types and constant helpers for the pipelined carry-lookahead add/subtract unit.
package cla_pkg;

  localparam int SAT_MAX_W = 256;

  typedef struct packed {
    logic valid;
    logic carry;
    logic sat_en;
  } stage_ctl_t;

  function automatic logic [SAT_MAX_W-1:0] max_pos(input int w);
    logic [SAT_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < SAT_MAX_W; i++)
      if (i < w - 1) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [SAT_MAX_W-1:0] max_neg(input int w);
    logic [SAT_MAX_W-1:0] r;
    r = '0;
    r[w-1] = 1'b1;
    return r;
  endfunction

  function automatic bit width_ok(input int w, input int b);
    return (b > 0) && (w >= b) && (w % b == 0) && (w <= SAT_MAX_W);
  endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational BLOCK-bit carry-lookahead group; every carry is a flat generate/propagate product.
module cla_block
  import cla_pkg::*;
#(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] x,
  input  logic [BLOCK-1:0] y,
  input  logic             c_in,
  output logic [BLOCK-1:0] s,
  output logic             c_out,
  output logic             c_msb
);

  logic [BLOCK-1:0] w_g;
  logic [BLOCK-1:0] w_p;
  logic [BLOCK:0]   w_c;

  assign w_g = x & y;
  assign w_p = x ^ y;

  always_comb begin
    logic cc;
    logic pp;
    w_c    = '0;
    w_c[0] = c_in;
    for (int i = 0; i < BLOCK; i++) begin
      cc = w_g[i];
      pp = w_p[i];
      for (int j = i - 1; j >= 0; j--) begin
        cc = cc | (pp & w_g[j]);
        pp = pp & w_p[j];
      end
      w_c[i+1] = cc | (pp & c_in);
    end
  end

  assign s     = w_p ^ w_c[BLOCK-1:0];
  assign c_out = w_c[BLOCK];
  assign c_msb = w_c[BLOCK-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined add/subtract: one lookahead group per stage, carry rippling stage to stage,
// valid/ready stream handshake, optional signed saturation and an overflow event counter.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             of,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             cnt_clr
);

  localparam int L    = WIDTH / BLOCK;
  localparam int LAST = L - 1;
  localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(max_pos(WIDTH));
  localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(max_neg(WIDTH));

  if (!width_ok(WIDTH, BLOCK)) begin : g_bad_cfg
    $error("cla_pipe_adder: WIDTH must be a non-zero multiple of BLOCK");
  end

  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_of;
  logic [CNT_W-1:0] r_cnt;
  logic             w_adv;

  // The whole pipe shifts together; a stalled output freezes every stage.
  assign w_adv    = !r_out_valid | out_ready;
  assign in_ready = w_adv;

  for (genvar k = 0; k < L; k++) begin : g_st
    localparam int LO = k * BLOCK;
    localparam int HW = WIDTH - LO;

    logic [HW-1:0]       r_a;
    logic [HW-1:0]       r_b;
    stage_ctl_t          r_ctl;
    logic [BLOCK-1:0]    w_s;
    logic                w_co;
    logic                w_cm;
    logic [LO+BLOCK-1:0] w_res;

    cla_block #(.BLOCK(BLOCK)) u_blk (
      .x     (r_a[BLOCK-1:0]),
      .y     (r_b[BLOCK-1:0]),
      .c_in  (r_ctl.carry),
      .s     (w_s),
      .c_out (w_co),
      .c_msb (w_cm)
    );

    if (k == 0) begin : g_head
      // Stage 0 boundary: B is inverted and carry forced to 1 for subtract, so cin drops out.
      assign w_res = w_s;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ctl <= '0;
        end else if (w_adv) begin
          r_ctl.valid  <= in_valid;
          r_ctl.carry  <= sub | cin;
          r_ctl.sat_en <= sat_en;
        end
      end
      always_ff @(posedge clk) begin
        if (w_adv) begin
          r_a <= a;
          r_b <= sub ? ~b : b;
        end
      end
    end else begin : g_body
      // Stage k boundary: finished low slices and untouched high operand slices move on together.
      logic [LO-1:0] r_lo;
      assign w_res = {w_s, r_lo};
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ctl <= '0;
        end else if (w_adv) begin
          r_ctl.valid  <= g_st[k-1].r_ctl.valid;
          r_ctl.carry  <= g_st[k-1].w_co;
          r_ctl.sat_en <= g_st[k-1].r_ctl.sat_en;
        end
      end
      always_ff @(posedge clk) begin
        if (w_adv) begin
          r_a  <= g_st[k-1].r_a[HW+BLOCK-1:BLOCK];
          r_b  <= g_st[k-1].r_b[HW+BLOCK-1:BLOCK];
          r_lo <= g_st[k-1].w_res;
        end
      end
    end

    if (k != LAST) begin : g_mid
      logic w_cm_unused;
      assign w_cm_unused = w_cm;
    end
  end

  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_res_sat;
  logic             w_last_vld;
  logic             w_of;
  logic             w_a_msb;

  assign w_raw      = g_st[LAST].w_res;
  assign w_last_vld = g_st[LAST].r_ctl.valid;
  assign w_of       = g_st[LAST].w_cm ^ g_st[LAST].w_co;
  assign w_a_msb    = g_st[LAST].r_a[BLOCK-1];
  assign w_res_sat  = (g_st[LAST].r_ctl.sat_en & w_of) ? (w_a_msb ? SAT_NEG : SAT_POS) : w_raw;

  // Output boundary: data only loads for real beats, so bubbles never disturb the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_of        <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= w_last_vld;
      if (w_last_vld) begin
        r_sum  <= w_res_sat;
        r_cout <= g_st[LAST].w_co;
        r_of   <= w_of;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (r_out_valid & out_ready & r_of & ~&r_cnt) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign of        = r_of;
  assign ovf_cnt   = r_cnt;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench: stimulus pushes hand-computed results, per-DUT monitors pop and compare.
module tb_cla_pipe_adder;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        sat;
    logic [31:0] s;
    logic        c;
    logic        o;
  } vec_t;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    bit          lat;
    int          t;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  exp_t q0[$];
  exp_t q1[$];
  vec_t v32[8];
  vec_t v16[8];

  logic        iv0, ir0, cin0, sub0, sat0, ov0, ordy0, cout0, of0, clr0;
  logic [31:0] a0, b0, sum0;
  logic [15:0] cnt0;
  logic        iv1, ir1, cin1, sub1, sat1, ov1, ordy1, cout1, of1, clr1;
  logic [15:0] a1, b1, sum1;
  logic [1:0]  cnt1;

  cla_pipe_adder #(.WIDTH(32), .BLOCK(8), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
    .cin(cin0), .sub(sub0), .sat_en(sat0), .out_valid(ov0), .out_ready(ordy0),
    .sum(sum0), .cout(cout0), .of(of0), .ovf_cnt(cnt0), .cnt_clr(clr0)
  );

  cla_pipe_adder #(.WIDTH(16), .BLOCK(16), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .cin(cin1), .sub(sub1), .sat_en(sat1), .out_valid(ov1), .out_ready(ordy1),
    .sum(sum1), .cout(cout1), .of(of1), .ovf_cnt(cnt1), .cnt_clr(clr1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && ov0 === 1'b1) begin
      if (q0.size() == 0) begin
        if (ordy0) chk("unexpected_out0", {32'h0, sum0}, 64'hDEAD);
      end else if (ordy0) begin
        e = q0.pop_front();
        chk("sum0", {32'h0, sum0}, {32'h0, e.s});
        chk("cout0", {63'h0, cout0}, {63'h0, e.c});
        chk("of0", {63'h0, of0}, {63'h0, e.o});
        if (e.lat) chk("latency0", 64'(cyc), 64'(e.t));
      end else begin
        e = q0[0];
        chk("held_sum0", {32'h0, sum0}, {32'h0, e.s});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && ov1 === 1'b1 && ordy1) begin
      if (q1.size() == 0) begin
        chk("unexpected_out1", {48'h0, sum1}, 64'hDEAD);
      end else begin
        e = q1.pop_front();
        chk("sum1", {48'h0, sum1}, {32'h0, e.s});
        chk("cout1", {63'h0, cout1}, {63'h0, e.c});
        chk("of1", {63'h0, of1}, {63'h0, e.o});
        if (e.lat) chk("latency1", 64'(cyc), 64'(e.t));
      end
    end
  end

  task automatic issue0(input vec_t v, input bit lat);
    bit acc = 0;
    int n = 0;
    while (!acc && n < 64) begin
      @(posedge clk); #2;
      a0 = v.a; b0 = v.b; cin0 = v.cin; sub0 = v.sub; sat0 = v.sat; iv0 = 1'b1;
      #1;
      if (ir0) begin
        acc = 1;
        q0.push_back('{v.s, v.c, v.o, lat, cyc + 1 + 4});
      end
      n++;
    end
    if (!acc) chk("issue0_timeout", 64'd0, 64'd1);
  endtask

  task automatic issue1(input vec_t v, input bit lat);
    bit acc = 0;
    int n = 0;
    while (!acc && n < 64) begin
      @(posedge clk); #2;
      a1 = v.a[15:0]; b1 = v.b[15:0]; cin1 = v.cin; sub1 = v.sub; sat1 = v.sat; iv1 = 1'b1;
      #1;
      if (ir1) begin
        acc = 1;
        q1.push_back('{v.s, v.c, v.o, lat, cyc + 1 + 1});
      end
      n++;
    end
    if (!acc) chk("issue1_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle0();
    @(posedge clk); #2;
    iv0 = 1'b0; a0 = 'x; b0 = 'x; cin0 = 1'bx; sub0 = 1'b0; sat0 = 1'b0;
  endtask

  task automatic idle1();
    @(posedge clk); #2;
    iv1 = 1'b0; a1 = 'x; b1 = 'x; cin1 = 1'bx; sub1 = 1'b0; sat1 = 1'b0;
  endtask

  task automatic drain0();
    int n = 0;
    while (q0.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    chk("drain0_left", 64'(q0.size()), 64'd0);
    @(posedge clk); #2;
  endtask

  task automatic drain1();
    int n = 0;
    while (q1.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    chk("drain1_left", 64'(q1.size()), 64'd0);
    @(posedge clk); #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int issued;
    bit waited;
    v32[0] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1};
    v32[1] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1};
    v32[2] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
    v32[3] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 32'h80000000, 1'b1, 1'b1};
    v32[4] = '{32'h12345678, 32'h12345670, 1'b1, 1'b0, 1'b0, 32'h2468ACE9, 1'b0, 1'b0};
    v32[5] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0};
    v32[6] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
    v32[7] = '{32'h00000123, 32'h00000123, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
    v16[0] = '{32'h7FFF, 32'h7FFF, 1'b0, 1'b0, 1'b0, 32'hFFFE, 1'b0, 1'b1};
    v16[1] = '{32'h7FFF, 32'h7FFF, 1'b0, 1'b0, 1'b1, 32'h7FFF, 1'b0, 1'b1};
    v16[2] = '{32'h8000, 32'hFFFF, 1'b0, 1'b0, 1'b0, 32'h7FFF, 1'b1, 1'b1};
    v16[3] = '{32'h8000, 32'hFFFF, 1'b0, 1'b0, 1'b1, 32'h8000, 1'b1, 1'b1};
    v16[4] = '{32'h1234, 32'h1230, 1'b1, 1'b0, 1'b0, 32'h2465, 1'b0, 1'b0};
    v16[5] = '{32'h0005, 32'h0007, 1'b0, 1'b1, 1'b0, 32'hFFFE, 1'b0, 1'b0};
    v16[6] = '{32'h8000, 32'h0001, 1'b0, 1'b1, 1'b0, 32'h7FFF, 1'b1, 1'b1};
    v16[7] = '{32'h0123, 32'h0123, 1'b1, 1'b1, 1'b0, 32'h0000, 1'b1, 1'b0};

    rst_n = 1'b0;
    iv0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0; sub0 = 1'b0; sat0 = 1'b0; ordy0 = 1'b1; clr0 = 1'b0;
    iv1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0; sat1 = 1'b0; ordy1 = 1'b1; clr1 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #3;
    chk("rst_out_valid0", {63'h0, ov0}, 64'd0);
    chk("rst_sum0", {32'h0, sum0}, 64'd0);
    chk("rst_cout0", {63'h0, cout0}, 64'd0);
    chk("rst_of0", {63'h0, of0}, 64'd0);
    chk("rst_cnt0", {48'h0, cnt0}, 64'd0);
    chk("rst_in_ready0", {63'h0, ir0}, 64'd1);
    chk("rst_out_valid1", {63'h0, ov1}, 64'd0);

    // single overflowing add with latency check, then the remaining directed vectors back to back
    issue0(v32[0], 1'b1);
    idle0();
    drain0();
    chk("cnt0_after_first", {48'h0, cnt0}, 64'd1);
    for (int i = 1; i < 8; i++) issue0(v32[i], 1'b1);
    idle0();
    drain0();
    chk("cnt0_after_vectors", {48'h0, cnt0}, 64'd5);

    // counter clear, count 3, then clear coinciding with an overflowing handshake
    @(posedge clk); #2; clr0 = 1'b1;
    @(posedge clk); #2; clr0 = 1'b0;
    chk("cnt0_cleared", {48'h0, cnt0}, 64'd0);
    for (int i = 0; i < 3; i++) issue0(v32[0], 1'b1);
    idle0();
    drain0();
    chk("cnt0_three", {48'h0, cnt0}, 64'd3);
    issue0(v32[0], 1'b1);
    idle0();
    waited = 0;
    for (int n = 0; n < 20 && !waited; n++) begin
      @(posedge clk); #2;
      if (ov0) begin
        clr0 = 1'b1;
        waited = 1;
        @(posedge clk); #2;
        clr0 = 1'b0;
      end
    end
    chk("clr_beat_seen", {63'h0, waited}, 64'd1);
    chk("cnt0_clear_wins", {48'h0, cnt0}, 64'd0);
    drain0();

    // streaming a=i, b=i
    for (int i = 1; i <= 6; i++) begin
      v = '{32'(i), 32'(i), 1'b0, 1'b0, 1'b0, 32'(2 * i), 1'b0, 1'b0};
      issue0(v, 1'b1);
    end
    idle0();
    drain0();

    // streaming with a 3-cycle output stall
    issued = 7;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk); #2;
      ordy0 = !(j >= 5 && j <= 7);
      if (issued <= 12) begin
        a0 = 32'(issued); b0 = 32'(issued); cin0 = 1'b0; sub0 = 1'b0; sat0 = 1'b0; iv0 = 1'b1;
      end else begin
        iv0 = 1'b0; a0 = 'x; b0 = 'x;
      end
      #1;
      if (j >= 5 && j <= 7) begin
        chk("stall_out_valid0", {63'h0, ov0}, 64'd1);
        chk("stall_in_ready0", {63'h0, ir0}, 64'd0);
      end
      if (iv0 && ir0) begin
        q0.push_back('{32'(2 * issued), 1'b0, 1'b0, 1'b0, 0});
        issued++;
      end
      if (issued > 12 && j >= 8) break;
    end
    chk("stall_all_issued", 64'(issued), 64'd13);
    ordy0 = 1'b1;
    idle0();
    drain0();

    // reset with beats in flight
    issue0(v32[0], 1'b1);
    idle0();
    drain0();
    chk("cnt0_before_reset", {48'h0, cnt0}, 64'd1);
    for (int i = 0; i < 3; i++) issue0(v32[4], 1'b0);
    @(posedge clk); #2;
    iv0 = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid0", {63'h0, ov0}, 64'd0);
    chk("midrst_sum0", {32'h0, sum0}, 64'd0);
    chk("midrst_cout0", {63'h0, cout0}, 64'd0);
    chk("midrst_of0", {63'h0, of0}, 64'd0);
    chk("midrst_cnt0", {48'h0, cnt0}, 64'd0);
    q0.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #3;
      chk("post_rst_out_valid0", {63'h0, ov0}, 64'd0);
    end

    // single-stage configuration, 2-bit saturating counter
    issue1(v16[0], 1'b1);
    issue1(v16[1], 1'b1);
    idle1();
    drain1();
    chk("cnt1_two", {62'h0, cnt1}, 64'd2);
    issue1(v16[2], 1'b1);
    issue1(v16[3], 1'b1);
    idle1();
    drain1();
    chk("cnt1_saturated", {62'h0, cnt1}, 64'd3);
    for (int i = 4; i < 8; i++) issue1(v16[i], 1'b1);
    idle1();
    drain1();
    chk("cnt1_still_saturated", {62'h0, cnt1}, 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead add/subtract unit. Next generation of the 32-bit combinational CLA adder.
- Splits WIDTH into BLOCK-bit lookahead groups, one group per pipeline stage, with carry rippling stage to stage.
- Adds a valid/ready stream handshake, a subtract mode, optional signed saturation, and a saturating overflow event counter.
- Sits between operand-issue logic and the result writeback stream of the arithmetic chip.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of BLOCK.
- BLOCK, 8, lookahead group width = bits resolved per stage.
- CNT_W, 16, width of overflow event counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  unit accepts beat this cycle
- a  in  WIDTH  operand A (two's complement or unsigned)
- b  in  WIDTH  operand B
- cin  in  1  carry in (add mode only)
- sub  in  1  1 = A - B, 0 = A + B + cin
- sat_en  in  1  1 = signed-saturate result on overflow
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out (add); not-borrow (sub)
- of  out  1  signed overflow of the unsaturated result
- ovf_cnt  out  CNT_W  count of accepted results with of=1
- cnt_clr  in  1  synchronous clear of ovf_cnt

Behaviour:
- Reset (async, rst_n=0): all stage valid bits 0, out_valid=0, sum=0, cout=0, of=0, ovf_cnt=0. in_ready=1 after reset.
- Stages: L = WIDTH/BLOCK. Latency is exactly L cycles from the accepting edge to out_valid=1 when not stalled.
- Stage k computes bits [k*BLOCK +: BLOCK] from registered operand slices and the registered carry of stage k-1.
- Lower result slices and upper operand slices travel in skew registers. Stage 0 carry-in = sub ? 1 : cin. B is bitwise inverted when sub=1, so cin is ignored in sub mode.
- Per-beat control (sub, sat_en) travels with the beat.
- Handshake:
  - adv = !out_valid | out_ready.
  - in_ready = adv.
  - Beat accepted when in_valid & in_ready.
  - When adv=1 every stage shifts one place; stage 0 loads the new beat, or a bubble if in_valid=0.
  - When adv=0 all stage registers hold and output is stable (sum/cout/of/out_valid unchanged).
  - Bubbles are not collapsed. Throughput is one beat per cycle when out_ready stays 1.
- Overflow: of = (A_msb == B'_msb) & (S_msb != A_msb), where B' is the post-inversion B and S is the raw sum.
- Saturation: if sat_en & of, sum = A_msb ? {1'b1,{WIDTH-1{0}}} : {1'b0,{WIDTH-1{1}}}. cout and of are unchanged, i.e. raw values.
- ovf_cnt:
  - Increments by 1 on each output handshake (out_valid & out_ready) with of=1.
  - Saturates at all-ones, no wrap.
  - If cnt_clr and an increment coincide, clear wins, giving a result of 0.
- WIDTH == BLOCK gives L=1: a single registered stage with identical handshake rules.
- Reset mid-operation discards all in-flight beats and never produces a partial result. ovf_cnt returns to 0.
- X on a, b or cin while in_valid=0 must not propagate to out_valid.

Decomposition:
- Package cla_pkg: saturation constant functions (max_pos(WIDTH), max_neg(WIDTH)), a stage-payload struct typedef (slice sums, carry, sub, sat_en, valid), and the elaboration check WIDTH % BLOCK == 0.
- Sub-module cla_block: combinational BLOCK-bit lookahead group with inputs x, y, c_in and outputs s, c_out, plus the carry into the MSB for overflow. Instantiated L times.

Test Plan:
- Add, sat_en=0: a=7FFFFFFF, b=7FFFFFFF, cin=0 -> after 4 cycles sum=FFFFFFFE, cout=0, of=1, ovf_cnt=1. Same beat with sat_en=1 -> sum=7FFFFFFF, of=1.
- Add: a=80000000, b=FFFFFFFF -> sum=7FFFFFFF, cout=1, of=1. With sat_en=1 -> sum=80000000. Add: a=12345678, b=12345670, cin=1 -> sum=2468ACE9, cout=0, of=0.
- Sub: a=00000005, b=00000007 -> sum=FFFFFFFE, cout=0, of=0. Sub: a=80000000, b=00000001 -> sum=7FFFFFFF, cout=1, of=1. Sub with cin=1: a=00000123, b=00000123 -> sum=0, cout=1 (cin ignored).
- Streaming plus backpressure:
  - Issue 6 back-to-back beats a=i, b=i (i=1..6) with out_ready=1 -> results 2,4,…,12 on consecutive cycles starting at cycle 4.
  - Then hold out_ready=0 for 3 cycles mid-stream -> in_ready=0, output held stable, no beat lost or duplicated.
- Counter: 3 overflowing beats, then cnt_clr asserted in the same cycle as a 4th overflowing handshake -> ovf_cnt=0. Force ovf_cnt to FFFF with CNT_W=16 and add one more overflowing beat -> stays FFFF.
- Reset: drop rst_n asynchronously with 3 beats in flight -> out_valid=0 and sum=0 immediately. After release, no stale result appears within 4 cycles. Also rerun the add vectors above with WIDTH=16, BLOCK=16, expecting latency 1.
